// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core, host and dmem signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, host_rdata, host_ack, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, host_req, host_we, host_addr, host_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, host_rdata, host_ack, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares single-port dmem between core M stage and a host port, CPU first with bounded host wait; DMEM_ARB_PERF_EN adds perf counters
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt,
  output logic [31:0]   perf_host_cnt
`endif
);
  localparam int CW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);
  typedef enum logic {S_CPU, S_HOST} state_t;
  state_t            state, state_nxt;
  logic [CW-1:0]     wait_cnt, wait_nxt;
  logic              in_host, host_pend, ack, mem_we, cpu_stall;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, host_rdata;
  assign in_host   = state == S_HOST;
  assign host_pend = bus.host_req & ~ack;
  // grant the host when the core is idle or the wait bound is hit; one access per grant
  always_comb begin
    state_nxt = S_CPU;
    wait_nxt  = '0;
    if (!in_host && host_pend) begin
      if (!bus.cpu_req || wait_cnt == WMAX) state_nxt = S_HOST;
      else wait_nxt = wait_cnt + 1'b1;
    end
  end
  // steer the dmem port to the granted side and stall the core while the host owns it
  always_comb begin
    mem_we    = in_host ? bus.host_we : bus.cpu_req & bus.cpu_we;
    mem_addr  = in_host ? bus.host_addr : bus.cpu_addr;
    mem_wdata = in_host ? bus.host_wdata : bus.cpu_wdata;
    cpu_stall = in_host & bus.cpu_req;
  end
  // state, wait counter and registered host completion
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CPU;
      wait_cnt   <= '0;
      ack        <= 1'b0;
      host_rdata <= '0;
    end else begin
      state      <= state_nxt;
      wait_cnt   <= wait_nxt;
      ack        <= in_host;
      if (in_host) host_rdata <= bus.mem_rdata;
    end
  end
`ifdef DMEM_ARB_PERF_EN
  // free-running stall and host-grant counters, wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_host_cnt  <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(cpu_stall);
      perf_host_cnt  <= perf_host_cnt + 32'(in_host);
    end
  end
`endif
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.host_ack   = ack;
  assign bus.host_rdata = host_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus host-read scoreboard for dmem_arbiter, with a behavioural dmem
module tb_dmem_arbiter;
  localparam int MAXW = 4;
  typedef struct {
    logic        creq, cwe;
    logic [31:0] caddr, cwd;
    logic        hreq, hwe;
    logic [31:0] haddr, hwd;
    logic        push;
    logic [31:0] hrd;
    logic        stall, ack, mwe;
    logic [31:0] maddr;
    logic        chk_crd;
    logic [31:0] crd;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem [256] = '{default: 32'h0};
  vec_t v [12];
  dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();
`ifdef DMEM_ARB_PERF_EN
  logic [31:0] perf_stall_cnt, perf_host_cnt;
`endif
  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_host_cnt(perf_host_cnt)
`endif
  );
  always #5 clk = ~clk;
  // dmem: combinational read, synchronous write
  assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  // every ack must complete the oldest outstanding request with its expected read data
  task automatic sb();
    logic [31:0] e;
    if (bus.host_ack) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL unexpected_ack: host_ack=1, expected no outstanding request");
      else begin
        e = exp_q.pop_front();
        if (bus.host_rdata === e) passed++;
        else $display("FAIL host_rdata: got %0h, expected %0h", bus.host_rdata, e);
      end
    end
  endtask
  task automatic drive(input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                       input logic hreq, input logic hwe, input logic [31:0] haddr, input logic [31:0] hwd);
    bus.cpu_req = creq; bus.cpu_we = cwe; bus.cpu_addr = caddr; bus.cpu_wdata = cwd;
    bus.host_req = hreq; bus.host_we = hwe; bus.host_addr = haddr; bus.host_wdata = hwd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    //        creq cwe caddr  cwd  hreq hwe haddr  hwd           push hrd            stall ack mwe maddr  chk crd
    v[0]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    v[1]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0};
    v[2]  = '{1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1, 32'hDEADBEEF};
    v[3]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    v[4]  = '{1'b1, 1'b1, 32'h20, 32'h5, 1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 32'h5, 1'b0, 1'b0, 1'b1, 32'h20, 1'b0, 32'h0};
    v[5]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    v[6]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h20, 1'b0, 32'h0};
    v[7]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    v[8]  = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    v[9]  = '{1'b1, 1'b0, 32'h30, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h20, 1'b0, 32'h0};
    v[10] = '{1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h20, 1'b1, 32'h5};
    v[11] = '{1'b0, 1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
    // reset held with random traffic; core stores land above 0x80, away from test addresses
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom), 1'($urandom), 32'h80 | ($urandom & 32'h7C), $urandom,
            1'($urandom), 1'($urandom), $urandom & 32'hFC, $urandom);
      @(negedge clk);
      sb();
      chk("rst_ack", 32'(bus.host_ack), 32'h0);
      chk("rst_stall", 32'(bus.cpu_stall), 32'h0);
      chk("rst_hrdata", bus.host_rdata, 32'h0);
      chk("rst_maddr", bus.mem_addr, bus.cpu_addr);
      chk("rst_mwe", 32'(bus.mem_we), 32'(bus.cpu_req & bus.cpu_we));
      chk("rst_mwdata", bus.mem_wdata, bus.cpu_wdata);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    // idle-bus host write, collision, held request and re-grant spacing
    for (int i = 0; i < 12; i++) begin
      drive(v[i].creq, v[i].cwe, v[i].caddr, v[i].cwd, v[i].hreq, v[i].hwe, v[i].haddr, v[i].hwd);
      if (v[i].push) exp_q.push_back(v[i].hrd);
      @(negedge clk);
      sb();
      chk($sformatf("v%0d_stall", i), 32'(bus.cpu_stall), 32'(v[i].stall));
      chk($sformatf("v%0d_ack", i), 32'(bus.host_ack), 32'(v[i].ack));
      chk($sformatf("v%0d_mwe", i), 32'(bus.mem_we), 32'(v[i].mwe));
      chk($sformatf("v%0d_maddr", i), bus.mem_addr, v[i].maddr);
      if (v[i].chk_crd) chk($sformatf("v%0d_crd", i), bus.cpu_rdata, v[i].crd);
      tick();
    end
    // reset pulse between scenarios
    reset = 1'b0;
    @(negedge clk);
    sb();
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall_rst", perf_stall_cnt, 32'h0);
    chk("perf_host_rst", perf_host_cnt, 32'h0);
`endif
    tick();
    reset = 1'b1;
    // starvation: the request-rise cycle plus MAXW waiting cycles go to the core, then one stall
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    exp_q.push_back(32'hDEADBEEF);
    for (int k = 0; k <= MAXW; k++) begin
      @(negedge clk);
      sb();
      chk($sformatf("starve_nostall%0d", k), 32'(bus.cpu_stall), 32'h0);
      tick();
    end
    @(negedge clk);
    sb();
    chk("starve_stall", 32'(bus.cpu_stall), 32'h1);
    chk("starve_maddr", bus.mem_addr, 32'h10);
    tick();
    @(negedge clk);
    sb();
    chk("starve_ack", 32'(bus.host_ack), 32'h1);
    chk("starve_ack_nostall", 32'(bus.cpu_stall), 32'h0);
    tick();
    bus.host_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      sb();
      chk($sformatf("starve_after%0d", k), 32'({bus.cpu_stall, bus.host_ack}), 32'h0);
      tick();
    end
`ifdef DMEM_ARB_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'h1);
    chk("perf_host", perf_host_cnt, 32'h1);
`endif
    // reset asserted in the middle of a host grant drops it without ack
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    sb();
    chk("midrst_grant_maddr", bus.mem_addr, 32'h0);
    tick();
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 32'h30;
    @(negedge clk);
    sb();
    chk("midrst_stall", 32'(bus.cpu_stall), 32'h1);
    chk("midrst_host_maddr", bus.mem_addr, 32'h10);
    reset = 1'b0;
    #1;
    chk("midrst_stall_clr", 32'(bus.cpu_stall), 32'h0);
    chk("midrst_maddr_cpu", bus.mem_addr, 32'h30);
    chk("midrst_hrdata", bus.host_rdata, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sb();
      chk($sformatf("midrst_noack%0d", k), 32'(bus.host_ack), 32'h0);
      tick();
    end
    // fresh idle-bus host read after the dropped grant
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
    exp_q.push_back(32'h5);
    @(negedge clk);
    sb();
    chk("post_grant_maddr", bus.mem_addr, 32'h0);
    tick();
    @(negedge clk);
    sb();
    chk("post_host_maddr", bus.mem_addr, 32'h20);
    tick();
    bus.host_req = 1'b0;
    @(negedge clk);
    sb();
    chk("post_ack", 32'(bus.host_ack), 32'h1);
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
